// File: rtl/updi_break_detect.sv
`default_nettype none
// ============================================================================
// Module   : updi_break_detect
// Purpose  : Separates UPDI BREAK conditions from ordinary low bits on the raw
//            line and flags single and (with UPDI_BREAK_DOUBLE_EN) double breaks.
// Revision : 1.0 - initial release
// ============================================================================
module updi_break_detect #(
    parameter int BREAK_MIN_CLK = 50000,
    parameter int GAP_MAX_CLK   = 200000,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       rx,
    output logic       in_break,
    output logic       break_det,
    output logic       double_break_det,
    output logic [7:0] break_count
);

    localparam int c_LOW_W = $clog2(BREAK_MIN_CLK + 1);
    localparam logic [c_LOW_W-1:0] c_LOW_MAX  = c_LOW_W'(BREAK_MIN_CLK);
    localparam logic [c_LOW_W-1:0] c_LOW_LAST = c_LOW_W'(BREAK_MIN_CLK - 1);
    localparam logic [c_LOW_W-1:0] c_LOW_ONE  = c_LOW_W'(1);

    generate
        if (BREAK_MIN_CLK < 2 || SYNC_STAGES < 2 || GAP_MAX_CLK < 1) begin : g_param_error
            $error("updi_break_detect: illegal parameter value");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOW   = 2'd1,
        S_BREAK = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t               r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_LOW_W-1:0]   r_low_cnt;
    logic                 w_rx_s;

    // Synchroniser runs independently of enable; idle-high reset value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
        end
    end

    assign w_rx_s = r_sync[SYNC_STAGES-1];

`ifdef UPDI_BREAK_DOUBLE_EN
    localparam int c_GAP_W = $clog2(GAP_MAX_CLK + 1);
    localparam logic [c_GAP_W-1:0] c_GAP_MAX  = c_GAP_W'(GAP_MAX_CLK);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_MAX_CLK - 1);

    logic [c_GAP_W-1:0] r_gap_cnt;
    logic               r_armed;
`else
    assign double_break_det = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_low_cnt   <= '0;
            in_break    <= 1'b0;
            break_det   <= 1'b0;
            break_count <= 8'd0;
`ifdef UPDI_BREAK_DOUBLE_EN
            r_gap_cnt        <= '0;
            r_armed          <= 1'b0;
            double_break_det <= 1'b0;
`endif
        end else begin
            break_det <= 1'b0;
`ifdef UPDI_BREAK_DOUBLE_EN
            double_break_det <= 1'b0;
`endif
            if (!enable) begin
                r_state   <= S_IDLE;
                r_low_cnt <= '0;
                in_break  <= 1'b0;
`ifdef UPDI_BREAK_DOUBLE_EN
                r_gap_cnt <= '0;
                r_armed   <= 1'b0;
`endif
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_rx_s) begin
                            r_state   <= S_LOW;
                            r_low_cnt <= c_LOW_ONE;
                        end
                    end

                    S_LOW: begin
                        if (w_rx_s) begin
                            // Too short for a break: an ordinary UART low bit.
                            r_state   <= S_IDLE;
                            r_low_cnt <= '0;
`ifdef UPDI_BREAK_DOUBLE_EN
                            r_armed   <= 1'b0;
`endif
                        end else begin
                            if (r_low_cnt != c_LOW_MAX) begin
                                r_low_cnt <= r_low_cnt + c_LOW_ONE;
                            end
                            if (r_low_cnt == c_LOW_LAST) begin
                                r_state  <= S_BREAK;
                                in_break <= 1'b1;
                            end
                        end
                    end

                    S_BREAK: begin
                        if (w_rx_s) begin
                            in_break  <= 1'b0;
                            break_det <= 1'b1;
                            r_low_cnt <= '0;
                            if (break_count != 8'hFF) begin
                                break_count <= break_count + 8'd1;
                            end
`ifdef UPDI_BREAK_DOUBLE_EN
                            r_state   <= S_GAP;
                            r_gap_cnt <= '0;
                            if (r_armed) begin
                                double_break_det <= 1'b1;
                                r_armed          <= 1'b0;
                            end else begin
                                r_armed <= 1'b1;
                            end
`else
                            r_state   <= S_IDLE;
`endif
                        end
                    end

`ifdef UPDI_BREAK_DOUBLE_EN
                    S_GAP: begin
                        if (!w_rx_s) begin
                            r_state   <= S_LOW;
                            r_low_cnt <= c_LOW_ONE;
                            r_gap_cnt <= '0;
                        end else if (r_gap_cnt == c_GAP_LAST) begin
                            // Gap too long: the pending half-pair is dropped.
                            r_state   <= S_IDLE;
                            r_gap_cnt <= c_GAP_MAX;
                            r_armed   <= 1'b0;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
                        end
                    end
`endif

                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_updi_break_detect.sv
`default_nettype none
// ============================================================================
// Module   : tb_updi_break_detect
// Purpose  : Self-checking bench for updi_break_detect against a run-length
//            reference model of the line; honours UPDI_BREAK_DOUBLE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_updi_break_detect;

    localparam int BMIN = 20;
    localparam int GMAX = 50;
    localparam int SYNC = 2;
`ifdef UPDI_BREAK_DOUBLE_EN
    localparam bit DBL_EN = 1'b1;
`else
    localparam bit DBL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       rx = 1'b1;
    logic       in_break;
    logic       break_det;
    logic       double_break_det;
    logic [7:0] break_count;

    updi_break_detect #(
        .BREAK_MIN_CLK (BMIN),
        .GAP_MAX_CLK   (GMAX),
        .SYNC_STAGES   (SYNC)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .rx               (rx),
        .in_break         (in_break),
        .break_det        (break_det),
        .double_break_det (double_break_det),
        .break_count      (break_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit [SYNC-1:0] m_hist = '1;
    int  low_run = 0;
    int  gap_highs = 0;
    bit  gap_active = 1'b0;
    bit  m_armed = 1'b0;
    bit  m_in_break = 1'b0;
    bit  m_brk_det = 1'b0;
    bit  m_dbl = 1'b0;
    int  m_count = 0;
    bit  s;

    always @(posedge clk) begin
        m_brk_det = 1'b0;
        m_dbl     = 1'b0;
        s = m_hist[SYNC-1];
        if (rst) begin
            m_hist = '1;
            low_run = 0; gap_highs = 0; gap_active = 1'b0; m_armed = 1'b0;
            m_in_break = 1'b0; m_count = 0;
        end else begin
            m_hist = {m_hist[SYNC-2:0], rx};
            if (!enable) begin
                low_run = 0; gap_active = 1'b0; m_armed = 1'b0; m_in_break = 1'b0;
            end else if (!s) begin
                if (!m_in_break) begin
                    low_run++;
                    gap_active = 1'b0;
                    if (low_run == BMIN) m_in_break = 1'b1;
                end
            end else if (m_in_break) begin
                m_in_break = 1'b0;
                low_run = 0;
                m_brk_det = 1'b1;
                if (m_count < 255) m_count++;
                if (DBL_EN) begin
                    if (m_armed) begin m_dbl = 1'b1; m_armed = 1'b0; end
                    else m_armed = 1'b1;
                    gap_active = 1'b1;
                    gap_highs = 0;
                end
            end else if (low_run > 0) begin
                low_run = 0;
                m_armed = 1'b0;
            end else if (gap_active) begin
                gap_highs++;
                if (gap_highs == GMAX) begin gap_active = 1'b0; m_armed = 1'b0; end
            end
        end
    end

    wire [10:0] w_obs = {in_break, break_det, double_break_det, break_count};
    wire [10:0] w_exp = {m_in_break, m_brk_det, m_dbl, 8'(m_count)};

    // ---------------- stimulus infrastructure ----------------
    typedef struct {
        logic lvl;
        logic en;
        logic rs;
        int   len;
    } seg_t;

    seg_t segs[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   brk_seen, dbl_seen, ib_seen, cyc;

    function automatic void add(input logic lvl, input logic en, input logic rs, input int len);
        seg_t sg;
        sg.lvl = lvl; sg.en = en; sg.rs = rs; sg.len = len;
        segs.push_back(sg);
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rx = 1'b0; enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rst = 1'b1;
            @(posedge clk); #1;
            n_vec++;
            if (w_obs !== 11'd0) begin
                n_err++;
                $display("FAIL reset cyc %0d: got %h want 000", i, w_obs);
            end
        end
        rst = 1'b0; rx = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if (w_obs !== w_exp) begin
                n_err++;
                $display("FAIL reset_idle cyc %0d: got %h want %h", i, w_obs, w_exp);
            end
        end
    endtask

    task automatic test_short_low();
        segs.delete();
        add(1'b0, 1'b1, 1'b0, BMIN - 1);
        add(1'b1, 1'b1, 1'b0, 10);
        brk_seen = 0; ib_seen = 0; cyc = 0;
        foreach (segs[k]) for (int i = 0; i < segs[k].len; i++) begin
            rx = segs[k].lvl; enable = segs[k].en; rst = segs[k].rs;
            @(posedge clk); #1;
            n_vec++; cyc++;
            if (w_obs !== w_exp) begin
                n_err++;
                $display("FAIL short_low cyc %0d: got %h want %h", cyc, w_obs, w_exp);
            end
            brk_seen += int'(break_det);
            ib_seen  += int'(in_break);
        end
        n_vec++;
        if (brk_seen != 0 || ib_seen != 0 || break_count !== 8'd0) begin
            n_err++;
            $display("FAIL short_low_summary: det=%0d in_break=%0d count=%0d want 0/0/0",
                     brk_seen, ib_seen, break_count);
        end
    endtask

    task automatic test_single();
        int t_rise, t_det;
        segs.delete();
        add(1'b0, 1'b1, 1'b0, BMIN);
        add(1'b1, 1'b1, 1'b0, GMAX + 10);
        brk_seen = 0; ib_seen = 0; cyc = 0; t_rise = BMIN; t_det = -1;
        foreach (segs[k]) for (int i = 0; i < segs[k].len; i++) begin
            rx = segs[k].lvl; enable = segs[k].en; rst = segs[k].rs;
            @(posedge clk); #1;
            if (w_obs !== w_exp) begin
                n_err++;
                $display("FAIL single cyc %0d: got %h want %h", cyc, w_obs, w_exp);
            end
            n_vec++;
            if (break_det && t_det < 0) t_det = cyc;
            brk_seen += int'(break_det);
            ib_seen  += int'(in_break);
            cyc++;
        end
        n_vec++;
        if (brk_seen != 1 || ib_seen != 1 || break_count !== 8'd1 || t_det - t_rise != SYNC) begin
            n_err++;
            $display("FAIL single_summary: det=%0d in_break_cyc=%0d count=%0d latency=%0d want 1/1/1/%0d",
                     brk_seen, ib_seen, break_count, t_det - t_rise, SYNC);
        end
    endtask

    task automatic test_double();
        int gaps[3] = '{40, GMAX, GMAX + 1};
        int exp_dbl;
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        segs.delete();
        foreach (gaps[g]) begin
            add(1'b0, 1'b1, 1'b0, 30);
            add(1'b1, 1'b1, 1'b0, gaps[g]);
            add(1'b0, 1'b1, 1'b0, 30);
            add(1'b1, 1'b1, 1'b0, GMAX + 10);
        end
        brk_seen = 0; dbl_seen = 0; cyc = 0;
        foreach (segs[k]) for (int i = 0; i < segs[k].len; i++) begin
            rx = segs[k].lvl; enable = segs[k].en; rst = segs[k].rs;
            @(posedge clk); #1;
            n_vec++; cyc++;
            if (w_obs !== w_exp) begin
                n_err++;
                $display("FAIL double cyc %0d: got %h want %h", cyc, w_obs, w_exp);
            end
            if (double_break_det && !break_det) begin
                n_err++;
                $display("FAIL double_coincident cyc %0d: got dbl without det", cyc);
            end
            brk_seen += int'(break_det);
            dbl_seen += int'(double_break_det);
        end
        exp_dbl = DBL_EN ? 2 : 0;
        n_vec++;
        if (brk_seen != 6 || dbl_seen != exp_dbl || break_count !== 8'd6) begin
            n_err++;
            $display("FAIL double_summary: det=%0d dbl=%0d count=%0d want 6/%0d/6",
                     brk_seen, dbl_seen, break_count, exp_dbl);
        end
    endtask

    task automatic test_interrupted();
        int c0;
        c0 = int'(break_count);
        segs.delete();
        add(1'b0, 1'b1, 1'b0, 25);
        add(1'b1, 1'b1, 1'b0, 10);
        add(1'b0, 1'b1, 1'b0, 5);
        add(1'b1, 1'b1, 1'b0, 10);
        add(1'b0, 1'b1, 1'b0, 25);
        add(1'b1, 1'b1, 1'b0, GMAX + 10);
        brk_seen = 0; dbl_seen = 0; cyc = 0;
        foreach (segs[k]) for (int i = 0; i < segs[k].len; i++) begin
            rx = segs[k].lvl; enable = segs[k].en; rst = segs[k].rs;
            @(posedge clk); #1;
            n_vec++; cyc++;
            if (w_obs !== w_exp) begin
                n_err++;
                $display("FAIL interrupted cyc %0d: got %h want %h", cyc, w_obs, w_exp);
            end
            brk_seen += int'(break_det);
            dbl_seen += int'(double_break_det);
        end
        n_vec++;
        if (brk_seen != 2 || dbl_seen != 0 || int'(break_count) != c0 + 2) begin
            n_err++;
            $display("FAIL interrupted_summary: det=%0d dbl=%0d count=%0d want 2/0/%0d",
                     brk_seen, dbl_seen, break_count, c0 + 2);
        end
    endtask

    task automatic test_abort();
        int c0;
        // Pass 0: reset pulsed at clk 22 of the low; pass 1: enable dropped instead.
        for (int pass = 0; pass < 2; pass++) begin
            c0 = (pass == 0) ? 0 : int'(break_count);
            segs.delete();
            add(1'b0, 1'b1, 1'b0, 22);
            if (pass == 0) begin
                add(1'b0, 1'b1, 1'b1, 1);
                add(1'b0, 1'b1, 1'b0, 2);
            end else begin
                add(1'b0, 1'b0, 1'b0, 3);
            end
            add(1'b1, 1'b1, 1'b0, 20);
            brk_seen = 0; ib_seen = 0; cyc = 0;
            foreach (segs[k]) for (int i = 0; i < segs[k].len; i++) begin
                rx = segs[k].lvl; enable = segs[k].en; rst = segs[k].rs;
                @(posedge clk); #1;
                n_vec++; cyc++;
                if (w_obs !== w_exp) begin
                    n_err++;
                    $display("FAIL abort%0d cyc %0d: got %h want %h", pass, cyc, w_obs, w_exp);
                end
                if (cyc > 22) begin
                    brk_seen += int'(break_det);
                    ib_seen  += int'(in_break);
                end
            end
            n_vec++;
            if (brk_seen != 0 || ib_seen != 0 || int'(break_count) != c0) begin
                n_err++;
                $display("FAIL abort%0d_summary: det=%0d in_break=%0d count=%0d want 0/0/%0d",
                         pass, brk_seen, ib_seen, break_count, c0);
            end
        end
    endtask

    task automatic test_random();
        segs.delete();
        for (int n = 0; n < 60; n++) begin
            logic en;
            en = ($urandom_range(0, 7) != 0);
            add(1'b0, en, 1'b0, $urandom_range(1, 35));
            add(1'b1, 1'b1, ($urandom_range(0, 24) == 0), 1);
            add(1'b1, 1'b1, 1'b0, $urandom_range(1, 70));
        end
        cyc = 0;
        foreach (segs[k]) for (int i = 0; i < segs[k].len; i++) begin
            rx = segs[k].lvl; enable = segs[k].en; rst = segs[k].rs;
            @(posedge clk); #1;
            n_vec++; cyc++;
            if (w_obs !== w_exp) begin
                n_err++;
                $display("FAIL random cyc %0d: got %h want %h", cyc, w_obs, w_exp);
            end
        end
    endtask

    task automatic test_saturation();
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        segs.delete();
        for (int n = 0; n < 260; n++) begin
            add(1'b0, 1'b1, 1'b0, BMIN);
            add(1'b1, 1'b1, 1'b0, 4);
        end
        add(1'b1, 1'b1, 1'b0, GMAX + 10);
        brk_seen = 0; cyc = 0;
        foreach (segs[k]) for (int i = 0; i < segs[k].len; i++) begin
            rx = segs[k].lvl; enable = segs[k].en; rst = segs[k].rs;
            @(posedge clk); #1;
            n_vec++; cyc++;
            if (w_obs !== w_exp) begin
                n_err++;
                $display("FAIL saturation cyc %0d: got %h want %h", cyc, w_obs, w_exp);
            end
            brk_seen += int'(break_det);
        end
        n_vec++;
        if (brk_seen != 260 || break_count !== 8'hFF) begin
            n_err++;
            $display("FAIL saturation_summary: det=%0d count=%0d want 260/255",
                     brk_seen, break_count);
        end
    endtask

    initial begin
        test_reset();
        test_short_low();
        test_single();
        test_double();
        test_interrupted();
        test_abort();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/updi_break_detect.md
# updi_break_detect

Receive-side companion to the UPDI double-break generator. It watches the raw UPDI line, separates BREAK conditions (line held low for at least `BREAK_MIN_CLK` clocks) from ordinary UART low bits, and flags single breaks and double breaks (two breaks in close succession). It sits between the pad input and the UPDI receiver/controller, which use it to resynchronise or abort the current transaction.

## Interface
- `BREAK_MIN_CLK`, default 50000: minimum consecutive low clocks that qualify as a break; must be ≥ 2.
- `GAP_MAX_CLK`, default 200000: maximum high clocks between two breaks that still pair into a double break.
- `SYNC_STAGES`, default 2: input synchroniser depth; must be ≥ 2.
- `clk` input 1: single clock.
- `rst` input 1: synchronous, active-high reset.
- `enable` input 1: detector active when high.
- `rx` input 1: raw, asynchronous UPDI line; idle high.
- `in_break` output 1: level, high while a qualified break is still being held low.
- `break_det` output 1: one-cycle pulse when a qualified break is released.
- `double_break_det` output 1: one-cycle pulse when the second break of a pair is released.
- `break_count` output 8: number of breaks detected since reset; saturates at 255.

## Operation
- Synchroniser: `rx` passes through `SYNC_STAGES` flops, all reset to 1, giving `rx_s`. The synchroniser runs regardless of `enable`.
- FSM states:
  - IDLE: `rx_s`=0 → LOW, `low_cnt`=1.
  - LOW: while `rx_s`=0, `low_cnt` increments. When `low_cnt` reaches `BREAK_MIN_CLK` → BREAK. If `rx_s`=1 first, the low was a short one: → IDLE, `armed` cleared.
  - BREAK: waits for `rx_s`=1, then pulses `break_det`, increments `break_count`, and → GAP.
  - GAP: `gap_cnt` counts high cycles. `rx_s`=0 → LOW, keeping `armed`. When `gap_cnt` reaches `GAP_MAX_CLK` → IDLE, `armed` cleared.
- Pairing:
  - On a break release with `armed`=0: set `armed`.
  - On a break release with `armed`=1: pulse `double_break_det` together with `break_det`, then clear `armed`.
  - A third break therefore starts a new pair.
- `low_cnt` width is $clog2(`BREAK_MIN_CLK`+1). `gap_cnt` width is $clog2(`GAP_MAX_CLK`+1). Neither wraps: a counter holds at its terminal value.
- `break_count` saturates at 8'hFF and never wraps.
- `enable`=0: FSM forced to IDLE; `low_cnt`, `gap_cnt` and `armed` cleared; `in_break`, `break_det` and `double_break_det` are 0. `break_count` holds its value.
- Reset, including mid-break: all state and outputs return to their reset values on the next edge. A line that is still low after reset must be low for a full `BREAK_MIN_CLK` again before it qualifies.

## Timing
- Reset values: `in_break`=0, `break_det`=0, `double_break_det`=0, `break_count`=0, FSM=IDLE, synchroniser flops=1.
- Input latency: an `rx` edge is visible on `rx_s` `SYNC_STAGES` edges later.
- `in_break` rises on the edge that registers the `BREAK_MIN_CLK`-th consecutive low sample of `rx_s`. A low of `BREAK_MIN_CLK`−1 samples never asserts it.
- On the edge that registers the first high sample in BREAK:
  - `in_break` falls.
  - `break_det` is high for exactly that one cycle.
  - `break_count` updates on the same edge.
- `double_break_det` is coincident with `break_det` and lasts one cycle.
- Gap boundary: a low sample arriving when `gap_cnt`=`GAP_MAX_CLK`−1 still pairs. At `gap_cnt`=`GAP_MAX_CLK` the FSM is in IDLE and the pair is lost.
- If `enable` falls while in BREAK, no `break_det` is issued.

## Configuration
- `UPDI_BREAK_DOUBLE_EN` defined: GAP state, `gap_cnt`, `armed` and `double_break_det` logic are compiled in, as described above.
- Not defined: `double_break_det` is tied to 0, and a break release goes BREAK → IDLE directly. `GAP_MAX_CLK` is unused. Single-break behaviour is unchanged.

## Test plan
All scenarios use `BREAK_MIN_CLK`=20, `GAP_MAX_CLK`=50, `SYNC_STAGES`=2.
1. Short low: `rx` low 19 clks, then high → `in_break` never asserts, `break_det`=0, `break_count`=0.
2. Single break: `rx` low 20 clks, then high → `in_break` high for the hold period; one `break_det` pulse 2 edges after `rx` rises (synchroniser latency); `break_count`=1. No pulse after 50 idle clks.
3. Double break (macro defined): two 30-clk lows separated by 40 clks high → `break_det` ×2, `double_break_det` once on the second release, `break_count`=2. Repeat with a 51-clk gap → no `double_break_det`.
4. Interrupted pairing: break, 10 clks high, 5-clk low, 10 clks high, break → no `double_break_det`; `break_count`=2.
5. Reset/enable mid-break: `rx` low 25 clks, `rst` pulsed at clk 22 → outputs 0; release gives no `break_det`. Same sequence with `enable`=0 at clk 22 → no `break_det`, `break_count` unchanged.
6. Saturation and macro off: 256 breaks → `break_count`=255. Scenario 3 rerun without the macro → `double_break_det` stays 0.
